// File: rtl/water_level_controller_if.sv
// Signal bundle between the water level controller and the tank model.
// The master side drives sensor and request inputs; the slave side is the controller.
interface water_level_controller_if;
  logic [1:0] water_box;
  logic       req_drip;
  logic       req_sprinkler;
  logic       stop;
  logic       ack_alarm;
  logic [1:0] state;
  logic       pump_en;
  logic       alarm;
  logic [1:0] level;
  logic       level_valid;

  modport master (
    output water_box, req_drip, req_sprinkler, stop, ack_alarm,
    input  state, pump_en, alarm, level, level_valid
  );

  modport slave (
    input  water_box, req_drip, req_sprinkler, stop, ack_alarm,
    output state, pump_en, alarm, level, level_valid
  );
endinterface

// File: rtl/water_level_controller.sv
// Closed-loop tank controller: debounces the raw level code, selects fill/drain
// rate from the filtered level and irrigation requests, and raises a fill-timeout alarm.
module water_level_controller #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned FILL_TIMEOUT  = 1000,
  parameter int unsigned TIMER_W       = 16
) (
  input logic                    clock,
  input logic                    reset,
  water_level_controller_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StFill, StDrip, StSprinkle, StBoth, StAlarm} fsm_e;

  localparam logic [TIMER_W-1:0] StableMax  = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TimeoutMax = TIMER_W'(FILL_TIMEOUT - 1);

  logic [1:0]         prev_q;
  logic               prev_valid_q;
  logic [TIMER_W-1:0] stab_q, stab_d;
  logic [1:0]         level_q, level_d;
  logic               level_valid_q, level_valid_d;
  logic               level_change;
  fsm_e               fsm_q, fsm_d;
  logic [TIMER_W-1:0] tmr_q, tmr_d;
  logic [1:0]         state_q, state_d;
  logic               pump_en_q, pump_en_d;
  logic               alarm_q, alarm_d;

  // stab counts repeats after the first sighting, so StableMax means STABLE_CYCLES edges seen.
  // prev_valid_q forces a fresh count after reset even if the input already matches.
  always_comb begin
    stab_d        = stab_q;
    level_d       = level_q;
    level_valid_d = level_valid_q;
    if (!prev_valid_q || (bus.water_box != prev_q)) begin
      stab_d = '0;
    end else if (stab_q < StableMax) begin
      stab_d = stab_q + 1'b1;
    end
    if (stab_d == StableMax) begin
      level_d       = bus.water_box;
      level_valid_d = 1'b1;
    end
  end

  assign level_change = level_valid_d && (level_d != level_q);

  always_comb begin
    fsm_d = fsm_q;
    if (fsm_q == StAlarm) begin
      if (bus.ack_alarm) fsm_d = StIdle;
    end else if (bus.stop || !level_valid_q) begin
      fsm_d = StIdle;
    end else if (fsm_q == StFill) begin
      if (level_q == 2'b11)      fsm_d = StIdle;
      else if (tmr_q >= TimeoutMax) fsm_d = StAlarm;
    end else if (level_q == 2'b00) begin
      fsm_d = StFill;
    end else begin
      case ({bus.req_sprinkler, bus.req_drip})
        2'b01:   fsm_d = StDrip;
        2'b10:   fsm_d = StSprinkle;
        2'b11:   fsm_d = StBoth;
        default: fsm_d = StIdle;
      endcase
    end
  end

  // Timer is held at zero outside FILL, which also gives the clear on FILL entry.
  always_comb begin
    tmr_d = '0;
    if ((fsm_q == StFill) && !bus.stop && !level_change) begin
      tmr_d = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
    end
  end

  // Outputs are decoded from the next state so they land on the same edge as fsm_q.
  always_comb begin
    state_d   = 2'b00;
    pump_en_d = 1'b1;
    alarm_d   = 1'b0;
    unique case (fsm_d)
      StIdle:     pump_en_d = 1'b0;
      StFill:     state_d   = 2'b00;
      StDrip:     state_d   = 2'b01;
      StSprinkle: state_d   = 2'b10;
      StBoth:     state_d   = 2'b11;
      StAlarm: begin
        pump_en_d = 1'b0;
        alarm_d   = 1'b1;
      end
      default:    pump_en_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q        <= 2'b00;
      prev_valid_q  <= 1'b0;
      stab_q        <= '0;
      level_q       <= 2'b00;
      level_valid_q <= 1'b0;
      fsm_q         <= StIdle;
      tmr_q         <= '0;
      state_q       <= 2'b00;
      pump_en_q     <= 1'b0;
      alarm_q       <= 1'b0;
    end else begin
      prev_q        <= bus.water_box;
      prev_valid_q  <= 1'b1;
      stab_q        <= stab_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
      fsm_q         <= fsm_d;
      tmr_q         <= tmr_d;
      state_q       <= state_d;
      pump_en_q     <= pump_en_d;
      alarm_q       <= alarm_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.pump_en     = pump_en_q;
  assign bus.alarm       = alarm_q;
  assign bus.level       = level_q;
  assign bus.level_valid = level_valid_q;

endmodule

// File: tb/tb_water_level_controller.sv
// Scoreboard bench for water_level_controller: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_water_level_controller;

  logic clock = 1'b0;
  logic reset;

  water_level_controller_if wl();

  water_level_controller #(
    .STABLE_CYCLES(4),
    .FILL_TIMEOUT (20),
    .TIMER_W      (16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (wl.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [1:0]  st;
    logic        pe;
    logic        al;
    logic [1:0]  lv;
    logic        lvv;
    bit          chk_st;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: expected at cycle %0d but monitor is at cycle %0d", e.name, e.cyc, cyc);
      end else if (wl.pump_en !== e.pe || wl.alarm !== e.al || wl.level !== e.lv ||
                   wl.level_valid !== e.lvv || (e.chk_st && wl.state !== e.st)) begin
        errors++;
        $display("FAIL %s @%0d: got st=%b pe=%b al=%b lv=%b lvv=%b want st=%b pe=%b al=%b lv=%b lvv=%b",
                 e.name, cyc, wl.state, wl.pump_en, wl.alarm, wl.level, wl.level_valid,
                 e.st, e.pe, e.al, e.lv, e.lvv);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int unsigned n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input int unsigned at, input string nm, input logic [1:0] st, input logic pe,
                     input logic al, input logic [1:0] lv, input logic lvv, input bit cs);
    exp_t e;
    e.cyc = at; e.name = nm; e.st = st; e.pe = pe; e.al = al; e.lv = lv; e.lvv = lvv;
    e.chk_st = cs;
    sb.push_back(e);
  endtask

  initial begin
    int unsigned c0, e0, g0, t0, s0;
    exp_t        left;
    reset            = 1'b1;
    wl.water_box     = 2'b00;
    wl.req_drip      = 1'b0;
    wl.req_sprinkler = 1'b0;
    wl.stop          = 1'b0;
    wl.ack_alarm     = 1'b0;

    // Reset release with water_box held at empty
    wait_until(3);
    c0 = cyc;
    chk(c0,     "reset_vals",  2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    chk(c0 + 3, "filter_3rd",  2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    chk(c0 + 4, "filter_4th",  2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    chk(c0 + 5, "fill_entry",  2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    reset = 1'b0;

    // Filling: 00 -> 01 -> 10 -> 11, 10 cycles each
    wait_until(c0 + 5);
    e0 = cyc;
    chk(e0 + 3,  "lag_01_pre",  2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    chk(e0 + 4,  "lag_01",      2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1);
    chk(e0 + 13, "lag_10_pre",  2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1);
    chk(e0 + 14, "lag_10",      2'b00, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1);
    chk(e0 + 24, "lag_11",      2'b00, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1);
    chk(e0 + 25, "full_idle",   2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
    wl.water_box = 2'b01;
    wait_until(e0 + 10);
    wl.water_box = 2'b10;
    wait_until(e0 + 20);
    wl.water_box = 2'b11;

    // Three-cycle glitch to empty must not reach level
    wait_until(e0 + 27);
    g0 = cyc;
    chk(g0 + 3, "glitch_a", 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
    chk(g0 + 5, "glitch_b", 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
    chk(g0 + 8, "glitch_c", 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
    wl.water_box = 2'b00;
    wait_until(g0 + 3);
    wl.water_box = 2'b11;

    // Requests at level 10, then stop during SPRINKLE
    wait_until(g0 + 9);
    t0 = cyc;
    chk(t0 + 4,  "lvl10",        2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
    chk(t0 + 6,  "no_req_idle",  2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
    chk(t0 + 7,  "drip",         2'b01, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1);
    chk(t0 + 9,  "both",         2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1);
    chk(t0 + 10, "both_hold",    2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1);
    chk(t0 + 11, "sprinkle",     2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1);
    chk(t0 + 13, "stop_idle",    2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
    chk(t0 + 15, "stop_hold",    2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
    chk(t0 + 16, "stop_release", 2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1);
    wl.water_box = 2'b10;
    wait_until(t0 + 6);
    wl.req_drip = 1'b1;
    wait_until(t0 + 8);
    wl.req_sprinkler = 1'b1;
    wait_until(t0 + 10);
    wl.req_drip = 1'b0;
    wait_until(t0 + 12);
    wl.stop = 1'b1;
    wait_until(t0 + 15);
    wl.stop = 1'b0;

    // Timeout: stuck at empty, alarm, ignore stop/requests, ack, refill, async reset
    wait_until(t0 + 17);
    s0 = cyc;
    chk(s0 + 1,  "drain_idle",   2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
    chk(s0 + 4,  "lvl00",        2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    chk(s0 + 5,  "refill",       2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    chk(s0 + 24, "pre_timeout",  2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    chk(s0 + 25, "timeout",      2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
    chk(s0 + 28, "alarm_sticky", 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
    chk(s0 + 31, "ack_idle",     2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    chk(s0 + 32, "ack_refill",   2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    chk(s0 + 33, "fill_hold",    2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    chk(s0 + 34, "async_reset",  2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    wl.req_sprinkler = 1'b0;
    wl.water_box     = 2'b00;
    wait_until(s0 + 26);
    wl.stop     = 1'b1;
    wl.req_drip = 1'b1;
    wait_until(s0 + 29);
    wl.stop     = 1'b0;
    wl.req_drip = 1'b0;
    wait_until(s0 + 30);
    wl.ack_alarm = 1'b1;
    wait_until(s0 + 31);
    wl.ack_alarm = 1'b0;
    wait_until(s0 + 34);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    while (sb.size() > 0) begin
      left = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expected at cycle %0d, never compared (now %0d)", left.name, left.cyc, cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
